// File: rtl/interfpga_pkg.sv
// Shared types and constants for the inter-FPGA transmit arbiter.
// INTERFPGA_ARB_HEADER_EN adds the header-frame states to the state encoding.
package interfpga_pkg;

  localparam logic [3:0] HDR_TAG          = 4'hA;
  localparam int         SEND_BUSY_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_HOLD      = 3'd3,
    ST_GAP       = 3'd4
`ifdef INTERFPGA_ARB_HEADER_EN
    ,
    ST_HDR_ISSUE = 3'd5,
    ST_HDR_WAIT  = 3'd6,
    ST_HDR_HOLD  = 3'd7
`endif
  } arb_state_t;

  function automatic logic [7:0] hdr_byte(input logic [1:0] id);
    return {HDR_TAG, 2'b00, id};
  endfunction

endpackage

// File: rtl/interfpga_tx_arbiter_if.sv
// Requester handshakes plus the link to the interfpga_send instance.
// master = arbiter side, slave = producers/sender side.
interface interfpga_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         link_data;
  logic               link_send;
  logic               link_busy;
  logic [1:0]         active_id;
  logic               frame_done;
  logic               err_timeout;

  modport master (
    input  req_data, req_valid, link_busy,
    output req_ready, link_data, link_send, active_id, frame_done, err_timeout
  );

  modport slave (
    output req_data, req_valid, link_busy,
    input  req_ready, link_data, link_send, active_id, frame_done, err_timeout
  );
endinterface

// File: rtl/interfpga_rr_pick.sv
// Combinational round-robin picker: first valid requester after rr_last,
// returned both as a one-hot grant and as an index.
module interfpga_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [1:0]       rr_last,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       idx
);
  logic [3:0] valid4;
  logic [3:0] grant4;
  logic [1:0] cand;
  logic       found;

  assign valid4 = 4'(valid);
  assign grant  = grant4[N_REQ-1:0];

  always_comb begin
    grant4 = '0;
    idx    = '0;
    cand   = '0;
    found  = 1'b0;
    // Search starts just after the last winner so it ends up lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = 2'((int'(rr_last) + k) % N_REQ);
      if (!found && valid4[cand]) begin
        grant4[cand] = 1'b1;
        idx          = cand;
        found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/interfpga_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one interfpga_send link among N_REQ producers.
// Define INTERFPGA_ARB_HEADER_EN to prefix each payload with a {HDR_TAG,00,id} header frame.
module interfpga_tx_arbiter
  import interfpga_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int GAP_CYCLES   = 1,
  parameter int BUSY_TIMEOUT = 3
) (
  input logic                     clk,
  input logic                     reset,
  interfpga_tx_arbiter_if.master  bus
);
  localparam logic [3:0] TO_LAST  = 4'(BUSY_TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam arb_state_t AFTER_FRAME = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
`ifdef INTERFPGA_ARB_HEADER_EN
  localparam arb_state_t FIRST_ISSUE = ST_HDR_ISSUE;
`else
  localparam arb_state_t FIRST_ISSUE = ST_ISSUE;
`endif

  arb_state_t       state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [7:0]       data_reg;
  logic [1:0]       id_reg;
  logic [1:0]       rr_last_reg;
  logic [N_REQ-1:0] grant;
  logic [1:0]       pick_idx;
  logic [7:0]       req_bytes [4];
  logic             take;
  logic             send;
  logic             done;
  logic             timeout;
  logic             hdr_phase;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      if (gi < N_REQ) begin : g_used
        assign req_bytes[gi] = bus.req_data[8*gi +: 8];
      end else begin : g_pad
        assign req_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  interfpga_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid   (bus.req_valid),
    .rr_last (rr_last_reg),
    .grant   (grant),
    .idx     (pick_idx)
  );

  // A busy sender in IDLE is not ours to drive; withhold every grant.
  assign take = (state_reg == ST_IDLE) && !bus.link_busy && (|bus.req_valid);

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    send       = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    hdr_phase  = 1'b0;
    unique case (state_reg)
      ST_IDLE:  if (take) state_next = FIRST_ISSUE;
      ST_ISSUE: begin
        send       = 1'b1;
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.link_busy) begin
          state_next = ST_HOLD;
        end else if (cnt_reg == TO_LAST) begin
          timeout    = 1'b1;
          state_next = AFTER_FRAME;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_HOLD: begin
        if (!bus.link_busy) begin
          done       = 1'b1;
          state_next = AFTER_FRAME;
        end
      end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) state_next = ST_IDLE;
        else                     cnt_next = cnt_reg + 4'd1;
      end
`ifdef INTERFPGA_ARB_HEADER_EN
      ST_HDR_ISSUE: begin
        send       = 1'b1;
        hdr_phase  = 1'b1;
        state_next = ST_HDR_WAIT;
      end
      ST_HDR_WAIT: begin
        hdr_phase = 1'b1;
        if (bus.link_busy) begin
          state_next = ST_HDR_HOLD;
        end else if (cnt_reg == TO_LAST) begin
          timeout    = 1'b1;
          state_next = AFTER_FRAME;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_HDR_HOLD: begin
        hdr_phase = 1'b1;
        if (!bus.link_busy) state_next = ST_ISSUE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      data_reg    <= '0;
      id_reg      <= '0;
      rr_last_reg <= 2'(N_REQ - 1);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (take) begin
        data_reg    <= req_bytes[pick_idx];
        id_reg      <= pick_idx;
        rr_last_reg <= pick_idx;
      end
    end
  end

  assign bus.req_ready   = (state_reg == ST_IDLE && !bus.link_busy) ? grant : '0;
  assign bus.link_data   = hdr_phase ? hdr_byte(id_reg) : data_reg;
  assign bus.link_send   = send;
  assign bus.active_id   = id_reg;
  assign bus.frame_done  = done;
  assign bus.err_timeout = timeout;
endmodule

// File: tb/tb_interfpga_tx_arbiter.sv
// Directed self-checking bench for interfpga_tx_arbiter with a simple sender model.
// Runs the header-frame scenario instead when INTERFPGA_ARB_HEADER_EN is defined.
module tb_interfpga_tx_arbiter;
  import interfpga_pkg::*;

  logic clk = 1'b0;
  logic reset;
  bit   sender_en  = 1'b1;
  bit   force_busy = 1'b0;
  int   busy_cnt   = 0;
  int   n_cmp      = 0;
  int   n_err      = 0;

  always #5 clk = ~clk;

  interfpga_tx_arbiter_if #(.N_REQ(4)) bus ();

  interfpga_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(1), .BUSY_TIMEOUT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Sender model: busy for SEND_BUSY_CYCLES cycles after it samples send.
  always @(posedge clk) begin
    if (!reset)                          busy_cnt <= 0;
    else if (bus.link_send && sender_en) busy_cnt <= SEND_BUSY_CYCLES;
    else if (busy_cnt != 0)              busy_cnt <= busy_cnt - 1;
  end
  assign bus.link_busy = (busy_cnt != 0) || force_busy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One nominal frame starting in IDLE with req_valid already set.
  task automatic do_frame(input int idx, input logic [7:0] d);
    bit fd_seen = 1'b0;
    #1;
    check_val($sformatf("grant%0d", idx), 32'(bus.req_ready), 32'(4'b0001 << idx));
    tick();
    check_val("issue_send", 32'(bus.link_send), 32'd1);
    check_val("issue_data", 32'(bus.link_data), 32'(d));
    check_val("issue_id", 32'(bus.active_id), 32'(idx));
    for (int c = 0; c < 12 && !fd_seen; c++) begin
      tick();
      if (bus.frame_done) begin
        fd_seen = 1'b1;
        check_val("done_data", 32'(bus.link_data), 32'(d));
      end
    end
    check_val("frame_done", 32'(fd_seen), 32'd1);
    tick();
    check_val("gap_ready", 32'(bus.req_ready), 32'd0);
    tick();
  endtask

  initial begin
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_data", 32'(bus.link_data), 32'd0);
    check_val("rst_send", 32'(bus.link_send), 32'd0);
    check_val("rst_id", 32'(bus.active_id), 32'd0);
    check_val("rst_done", 32'(bus.frame_done), 32'd0);
    check_val("rst_err", 32'(bus.err_timeout), 32'd0);
    reset = 1'b1;
    #1;
    check_val("idle_ready", 32'(bus.req_ready), 32'd0);

`ifdef INTERFPGA_ARB_HEADER_EN
    begin
      int  sends = 0;
      int  dones = 0;
      bus.req_valid = 4'b0100;
      bus.req_data  = 32'h0031_0000;
      #1;
      check_val("hdr_grant", 32'(bus.req_ready), 32'h4);
      tick();
      bus.req_valid = '0;
      check_val("hdr_send", 32'(bus.link_send), 32'd1);
      check_val("hdr_data", 32'(bus.link_data), 32'hA2);
      for (int c = 0; c < 20; c++) begin
        tick();
        if (bus.link_send) begin
          sends++;
          check_val("pay_data", 32'(bus.link_data), 32'h31);
        end
        if (bus.frame_done) dones++;
      end
      check_val("pay_sends", 32'(sends), 32'd1);
      check_val("dones", 32'(dones), 32'd1);
    end
`else
    // Single request, cycle by cycle.
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_005C;
    #1;
    check_val("t1_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    #1;
    check_val("t1_send", 32'(bus.link_send), 32'd1);
    check_val("t1_data", 32'(bus.link_data), 32'h5C);
    check_val("t1_nogrant", 32'(bus.req_ready), 32'd0);
    tick();
    check_val("t1_wait_send", 32'(bus.link_send), 32'd0);
    check_val("t1_busy", 32'(bus.link_busy), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("t1_hold_data", 32'(bus.link_data), 32'h5C);
      check_val("t1_hold_done", 32'(bus.frame_done), 32'd0);
    end
    tick();
    check_val("t1_done", 32'(bus.frame_done), 32'd1);
    check_val("t1_done_data", 32'(bus.link_data), 32'h5C);
    bus.req_valid = 4'b0001;
    tick();
    check_val("t1_gap_ready", 32'(bus.req_ready), 32'd0);
    check_val("t1_gap_done", 32'(bus.frame_done), 32'd0);
    tick();
    check_val("t1_next_ready", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;

    // Round robin with rr_last=1: order 2,3,0,1.
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h0000_1100;
    do_frame(1, 8'h11);
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'hD3D2_D1D0;
    do_frame(2, 8'hD2);
    do_frame(3, 8'hD3);
    do_frame(0, 8'hD0);
    do_frame(1, 8'hD1);
    bus.req_valid = '0;

    // Busy never rises: timeout on the third WAIT_BUSY cycle.
    sender_en     = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_0099;
    #1;
    check_val("t3_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check_val("t3_send", 32'(bus.link_send), 32'd1);
    tick();
    check_val("t3_w1_err", 32'(bus.err_timeout), 32'd0);
    tick();
    check_val("t3_w2_err", 32'(bus.err_timeout), 32'd0);
    tick();
    check_val("t3_w3_err", 32'(bus.err_timeout), 32'd1);
    check_val("t3_no_done", 32'(bus.frame_done), 32'd0);
    tick();
    check_val("t3_gap_err", 32'(bus.err_timeout), 32'd0);
    check_val("t3_gap_ready", 32'(bus.req_ready), 32'd0);
    sender_en = 1'b1;
    tick();
    bus.req_valid = 4'b0011;
    bus.req_data  = 32'h0000_4499;
    do_frame(1, 8'h44);
    bus.req_valid = '0;

    // Foreign busy while idle withholds the grant.
    force_busy    = 1'b1;
    bus.req_valid = 4'b0001;
    #1;
    check_val("t4_busy_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check_val("t4_busy_ready2", 32'(bus.req_ready), 32'd0);
    check_val("t4_busy_send", 32'(bus.link_send), 32'd0);
    force_busy = 1'b0;
    do_frame(0, 8'h99);
    bus.req_valid = '0;

    // Reset in HOLD.
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'hD342_D1D0;
    #1;
    check_val("t5_ready", 32'(bus.req_ready), 32'h4);
    tick();
    tick();
    tick();
    check_val("t5_hold_data", 32'(bus.link_data), 32'h42);
    reset         = 1'b0;
    bus.req_valid = 4'b1111;
    tick();
    #1;
    check_val("t5_rst_send", 32'(bus.link_send), 32'd0);
    check_val("t5_rst_data", 32'(bus.link_data), 32'd0);
    check_val("t5_rst_id", 32'(bus.active_id), 32'd0);
    check_val("t5_rst_ready", 32'(bus.req_ready), 32'h1);
    reset = 1'b1;
    do_frame(0, 8'hD0);
    bus.req_valid = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/interfpga_tx_arbiter.md
Name: interfpga_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one interfpga_send link between N_REQ byte producers.
- Accepts bytes over per-requester valid/ready handshakes.
- Presents the winning byte to the sender, pulses its send input, and holds data stable until the sender's busy window ends.
- Sits between on-board producers (keypad, game logic, etc.) and the interfpga_send instance.

Parameters:
N_REQ, 4, number of requesters (2..4).
GAP_CYCLES, 1, minimum idle cycles between frames after busy falls (0..15).
BUSY_TIMEOUT, 3, cycles allowed in WAIT_BUSY before declaring a link fault (1..7).

Ports:
clk  input  1  clock; all flops update on posedge.
reset  input  1  synchronous, active-low reset.
req_data  input  8*N_REQ  byte of requester i at [8i+7:8i].
req_valid  input  N_REQ  requester i has a byte pending.
req_ready  output  N_REQ  one-hot grant; a transfer occurs on the edge where req_valid[i]&req_ready[i].
link_data  output  8  byte to interfpga_send data.
link_send  output  1  to interfpga_send send; high for exactly one cycle per frame.
link_busy  input  1  from interfpga_send busy.
active_id  output  2  index of the requester whose byte is in flight.
frame_done  output  1  one-cycle pulse when busy falls at frame end.
err_timeout  output  1  one-cycle pulse on busy timeout.

Behaviour:
- Reset (reset==0 at posedge) values:
  - state=IDLE; link_data=0; link_send=0; active_id=0; frame_done=0; err_timeout=0.
  - rr_last=N_REQ-1, so requester 0 has first priority; gap counter=0.
- States: IDLE, ISSUE, WAIT_BUSY, HOLD, GAP (plus HDR_ISSUE, HDR_WAIT, HDR_HOLD with the optional feature).
- IDLE:
  - req_ready is combinational and one-hot: the first valid requester searching rr_last+1, rr_last+2, … modulo N_REQ.
  - req_ready is all-zero in every other state.
  - On transfer: latch link_data=req_data[i], active_id=i, rr_last=i; next state ISSUE.
- ISSUE: link_send=1 for this single cycle; next state WAIT_BUSY.
- WAIT_BUSY:
  - link_busy==1 → HOLD.
  - After BUSY_TIMEOUT cycles with busy low: pulse err_timeout, go to GAP. The byte is dropped with no retry.
- HOLD:
  - link_data and active_id stay frozen while link_busy==1 (nominally 4 cycles).
  - On the first cycle with busy==0: pulse frame_done; go to GAP, or to IDLE if GAP_CYCLES==0.
- GAP: count GAP_CYCLES cycles, then IDLE.
- Nominal frame period with GAP_CYCLES=1: IDLE→ISSUE→WAIT_BUSY(1)→HOLD(4)→GAP(1) = 8 cycles per byte.
- link_busy high while in IDLE (sender is not ours, or was reset skewed): the arbiter withholds req_ready until busy is low.
- req_valid deasserting without ready: no effect; no requester is locked. A requester is never granted twice in a row while another requester is valid.
- Reset mid-frame: return to IDLE immediately; the partial frame is the sender's concern. Sender and arbiter share the same reset net.

Optional Feature:
- Macro: INTERFPGA_ARB_HEADER_EN.
- Defined: each transfer sends two frames.
  - Header first: byte {4'hA, 2'b00, active_id}, sequenced via HDR_ISSUE → HDR_WAIT → HDR_HOLD, with the same timeout rules.
  - The header HDR_HOLD exit goes straight to ISSUE for the payload, with no gap.
  - frame_done pulses only after the payload frame.
  - A timeout on the header aborts the payload.
- Undefined: payload frame only; the HDR_* states do not exist.

Decomposition:
- Package interfpga_pkg holds:
  - state encodings;
  - HDR_TAG=4'hA;
  - nominal SEND_BUSY_CYCLES=4.
- One sub-module: interfpga_rr_pick. Combinational round-robin picker taking req_valid and rr_last, producing a one-hot grant and its index.

Test Plan:
- Single request: req_valid=0001, data 8'h5C, sender model busy for 4 cycles → link_send pulses 1 cycle after transfer; link_data=8'h5C stable until busy falls; frame_done pulses; next ready after 1 gap cycle.
- All valid (1111), rr_last=1 → grant order 2,3,0,1; each req_ready is one-hot and only in IDLE.
- Busy never rises, BUSY_TIMEOUT=3 → err_timeout pulses on the 3rd WAIT_BUSY cycle; no frame_done; next grant proceeds normally.
- Reset driven low during HOLD → next cycle link_send=0, link_data=0, req_ready re-evaluated from requester 0.
- HEADER_EN, requester 2 sends 8'h31 → link_data sequence 8'hA2 then 8'h31; two send pulses; one frame_done.
- Back-to-back with a real interfpga_send and interfpga_receive loop, bytes 00..FF from alternating requesters → receiver gets every byte in grant order.
